v2f_seq_udiv_wide: RTL and testbench

- Iterative unsigned divider for operands wider than 32 bits. It produces quotient and remainder in one shared datapath.
- It is the inverse of the wide-multiply narrowing rules. Techmap rules instantiate it when a $div or $mod cell is wider than 32 bits.
- All internal arithmetic and compares are built from 32-bit limbs, so the combinator backend never sees a signal wider than 32 bits.
- Unsigned compares are done limb-wise with the 0x80000000 bias, which keeps them correct on signed 32-bit signals.

---
 rtl/v2f_seq_udiv_wide.sv | 154 +++++++++++++++
 tb/tb_v2f_seq_udiv_wide.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/v2f_seq_udiv_wide.sv
// Iterative restoring unsigned divider for operands wider than 32 bits.
// All compare and subtract logic works on 32-bit limbs so no wider arithmetic signal exists.
module v2f_seq_udiv_wide #(
    parameter int WIDTH = 64
) (
    input  logic             CLK,
    input  logic             ARST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DZ
);

    localparam int LIMBS = WIDTH / 32;
    localparam int CW    = $clog2(WIDTH);

    generate
        if ((WIDTH % 32) != 0 || WIDTH < 64) begin : g_bad_width
            $error("v2f_seq_udiv_wide: WIDTH must be a multiple of 32 and at least 64");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic [CW-1:0]    cnt;
    logic             dz;
    logic             take;
    logic             b_zero;

    // Unsigned less-than on signed-friendly limbs: flipping the MSB maps unsigned order onto signed order.
    function automatic logic lt32(input logic [31:0] x, input logic [31:0] y);
        lt32 = $signed(x ^ 32'h8000_0000) < $signed(y ^ 32'h8000_0000);
    endfunction

    always_comb begin
        b_zero = 1'b1;
        for (int i = 0; i < LIMBS; i++) begin
            if (B[i*32 +: 32] != 32'h0) begin
                b_zero = 1'b0;
            end
        end
    end

    always_comb begin
        logic        decided;
        logic        borrow;
        logic [31:0] ra;
        logic [31:0] da;
        rem_sh  = {rem[WIDTH-2:0], dq[WIDTH-1]};
        take    = 1'b1;
        decided = 1'b0;
        for (int i = LIMBS - 1; i >= 0; i--) begin
            if (!decided && (rem_sh[i*32 +: 32] != divisor[i*32 +: 32])) begin
                take    = lt32(divisor[i*32 +: 32], rem_sh[i*32 +: 32]);
                decided = 1'b1;
            end
        end
        borrow  = 1'b0;
        rem_sub = '0;
        for (int i = 0; i < LIMBS; i++) begin
            ra = rem_sh[i*32 +: 32];
            da = divisor[i*32 +: 32];
            rem_sub[i*32 +: 32] = ra - da - {31'b0, borrow};
            borrow = lt32(ra, da) | ((ra == da) & borrow);
        end
    end

    always_ff @(posedge CLK or negedge ARST) begin
        if (!ARST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        IN_READY   = 1'b0;
        OUT_VALID  = 1'b0;
        case (state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    state_next = b_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The dividend register doubles as the quotient: each step shifts a dividend bit out and a quotient bit in.
    always_ff @(posedge CLK or negedge ARST) begin
        if (!ARST) begin
            dq      <= '0;
            divisor <= '0;
            rem     <= '0;
            cnt     <= '0;
            dz      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (IN_VALID) begin
                        divisor <= B;
                        cnt     <= CW'(WIDTH - 1);
                        if (b_zero) begin
                            dq  <= '1;
                            rem <= A;
                            dz  <= 1'b1;
                        end else begin
                            dq  <= A;
                            rem <= '0;
                            dz  <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem <= take ? rem_sub : rem_sh;
                    dq  <= {dq[WIDTH-2:0], take};
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Q  = dq;
    assign R  = rem;
    assign DZ = dz;

endmodule

// File: tb/tb_v2f_seq_udiv_wide.sv
// Directed and random checks of the wide sequential divider against 64-bit arithmetic.
module tb_v2f_seq_udiv_wide;

    logic        CLK;
    logic        ARST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [63:0] A;
    logic [63:0] B;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [63:0] Q;
    logic [63:0] R;
    logic        DZ;

    int n_checks;
    int n_fail;

    v2f_seq_udiv_wide #(.WIDTH(64)) dut (
        .CLK(CLK),
        .ARST(ARST),
        .IN_VALID(IN_VALID),
        .IN_READY(IN_READY),
        .A(A),
        .B(B),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .Q(Q),
        .R(R),
        .DZ(DZ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    // Presents one operand pair and returns edges from the accepting edge until OUT_VALID rises.
    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, output int lat);
        int waited;
        waited = 0;
        while (!IN_READY && waited < 200) begin
            tick();
            waited++;
        end
        checkOutput("in_ready_before_accept", {63'b0, IN_READY}, 64'd1);
        IN_VALID = 1'b1;
        A = a;
        B = b;
        tick();
        IN_VALID = 1'b0;
        A = {$urandom, $urandom};
        B = {$urandom, $urandom};
        lat = 1;
        while (!OUT_VALID && lat < 200) begin
            tick();
            lat++;
        end
        checkOutput("out_valid_seen", {63'b0, OUT_VALID}, 64'd1);
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] exp_q;
        logic [63:0] exp_r;
        logic        exp_dz;
        int          exp_lat;
        int          lat;
        if (b == 64'd0) begin
            exp_q   = '1;
            exp_r   = a;
            exp_dz  = 1'b1;
            exp_lat = 1;
        end else begin
            exp_q   = a / b;
            exp_r   = a % b;
            exp_dz  = 1'b0;
            exp_lat = 65;
        end
        OUT_READY = (hold == 0);
        applyStimulus(a, b, lat);
        checkOutput("latency", 64'(lat), 64'(exp_lat));
        checkOutput("quotient", Q, exp_q);
        checkOutput("remainder", R, exp_r);
        checkOutput("dz", {63'b0, DZ}, {63'b0, exp_dz});
        if (!DZ) begin
            checkOutput("identity_a_eq_qb_plus_r", Q * b + R, a);
            checkOutput("remainder_below_divisor", {63'b0, (R < b)}, 64'd1);
        end
        for (int k = 0; k < hold; k++) begin
            tick();
            checkOutput("hold_q", Q, exp_q);
            checkOutput("hold_r", R, exp_r);
            checkOutput("hold_dz", {63'b0, DZ}, {63'b0, exp_dz});
            checkOutput("hold_out_valid", {63'b0, OUT_VALID}, 64'd1);
            checkOutput("hold_in_ready", {63'b0, IN_READY}, 64'd0);
        end
        OUT_READY = 1'b1;
        tick();
        checkOutput("release_out_valid", {63'b0, OUT_VALID}, 64'd0);
        checkOutput("release_in_ready", {63'b0, IN_READY}, 64'd1);
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] rb;
        int          mode;
        n_checks  = 0;
        n_fail    = 0;
        ARST      = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        A         = '0;
        B         = '0;

        #3;
        checkOutput("reset_in_ready", {63'b0, IN_READY}, 64'd1);
        checkOutput("reset_out_valid", {63'b0, OUT_VALID}, 64'd0);
        checkOutput("reset_q", Q, 64'd0);
        checkOutput("reset_r", R, 64'd0);
        checkOutput("reset_dz", {63'b0, DZ}, 64'd0);
        tick();
        tick();
        ARST = 1'b1;
        tick();

        $display("[TB] directed operations");
        run_op(64'd100, 64'd7, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0);
        run_op(64'd5, 64'd9, 0);
        run_op(64'h1234, 64'd0, 0);
        run_op(64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 0);
        run_op(64'hDEAD_BEEF_0123_4567, 64'h0000_0001_0000_0001, 10);
        run_op(64'h55, 64'd0, 10);

        $display("[TB] reset during CALC");
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        A = 64'hFEDC_BA98_7654_3210;
        B = 64'd12345;
        tick();
        IN_VALID = 1'b0;
        repeat (30) tick();
        #2;
        ARST = 1'b0;
        #1;
        checkOutput("abort_out_valid", {63'b0, OUT_VALID}, 64'd0);
        checkOutput("abort_in_ready", {63'b0, IN_READY}, 64'd1);
        checkOutput("abort_q", Q, 64'd0);
        checkOutput("abort_r", R, 64'd0);
        checkOutput("abort_dz", {63'b0, DZ}, 64'd0);
        tick();
        ARST = 1'b1;
        tick();
        checkOutput("post_reset_out_valid", {63'b0, OUT_VALID}, 64'd0);
        checkOutput("post_reset_in_ready", {63'b0, IN_READY}, 64'd1);
        repeat (70) tick();
        checkOutput("no_aborted_result", {63'b0, OUT_VALID}, 64'd0);
        run_op(64'd100, 64'd7, 0);

        $display("[TB] random operations");
        for (int n = 0; n < 400; n++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            mode = $urandom_range(0, 9);
            case (mode)
                0: rb = 64'd1;
                1: rb = ra;
                2: ra = 64'd0;
                3: rb = {32'd0, $urandom};
                4: rb = 64'($urandom_range(1, 255));
                5: rb = 64'd0;
                6: ra = {32'd0, $urandom};
                default: ;
            endcase
            run_op(ra, rb, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
